// File: rtl/pe_alu_xbar_pkg.sv
// Shared types and config-field layout for the pe_alu_xbar processing element.
// The config word packs, from the LSB up: opcode, out_sel, then four 2-bit crossbar selects.
package pe_alu_xbar_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_MUL   = 4'd2,
        ALU_AND   = 4'd3,
        ALU_OR    = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SHL   = 4'd6,
        ALU_LSHR  = 4'd7,
        ALU_ASHR  = 4'd8,
        ALU_EQ    = 4'd9,
        ALU_LT    = 4'd10,
        ALU_LTU   = 4'd11,
        ALU_PASSA = 4'd12,
        ALU_PASSB = 4'd13,
        ALU_MIN   = 4'd14,
        ALU_ZERO  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_IN0 = 2'd0,
        SRC_IN1 = 2'd1,
        SRC_ALU = 2'd2,
        SRC_MEM = 2'd3
    } xbar_src_e;

    localparam int CFG_W    = 13;
    localparam int OP_LSB   = 0;
    localparam int OP_W     = 4;
    localparam int OSEL_BIT = 4;
    localparam int SEL_LSB  = 5;
    localparam int SEL_W    = 2;
    localparam int NUM_XOUT = 4;

endpackage

// File: rtl/pe_alu_xbar_alu2.sv
// Two-operand ALU: combinational op decode feeding a free-running result register.
// All arithmetic wraps; compares yield a zero-extended 0/1.
module alu2
    import pe_alu_xbar_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  alu_op_e         op_i,
    input  logic [size-1:0] a_i,
    input  logic [size-1:0] b_i,
    output logic [size-1:0] result_o
);

    logic [size-1:0] res_d, res_q;
    logic [4:0]      shamt;

    assign shamt = b_i[4:0];

    always_comb begin
        res_d = '0;
        case (op_i)
            ALU_ADD:   res_d = a_i + b_i;
            ALU_SUB:   res_d = a_i - b_i;
            ALU_MUL:   res_d = a_i * b_i;
            ALU_AND:   res_d = a_i & b_i;
            ALU_OR:    res_d = a_i | b_i;
            ALU_XOR:   res_d = a_i ^ b_i;
            ALU_SHL:   res_d = a_i << shamt;
            ALU_LSHR:  res_d = a_i >> shamt;
            ALU_ASHR:  res_d = $unsigned($signed(a_i) >>> shamt);
            ALU_EQ:    res_d = {{(size-1){1'b0}}, a_i == b_i};
            ALU_LT:    res_d = {{(size-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_LTU:   res_d = {{(size-1){1'b0}}, a_i < b_i};
            ALU_PASSA: res_d = a_i;
            ALU_PASSB: res_d = b_i;
            ALU_MIN:   res_d = ($signed(a_i) < $signed(b_i)) ? a_i : b_i;
            ALU_ZERO:  res_d = '0;
            default:   res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) res_q <= '0;
        else       res_q <= res_d;
    end

    assign result_o = res_q;

endmodule

// File: rtl/pe_alu_xbar.sv
// CGRA processing element: 4x4 input crossbar, registered ALU, 2:1 output mux,
// all configured through a 13-bit serial scan chain clocked on the datapath clock.
module pe_alu_xbar
    import pe_alu_xbar_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] mem_in,
    output logic [size-1:0] out0,
    output logic [size-1:0] xbar_out2,
    output logic [size-1:0] xbar_out3
);

    logic [CFG_W-1:0]                cfg_d, cfg_q;
    logic [NUM_XOUT-1:0][size-1:0]   xbar;
    logic [size-1:0]                 alu_res;

    assign cfg_d = config_en ? {cfg_q[CFG_W-2:0], config_in} : cfg_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cfg_q <= '0;
        else       cfg_q <= cfg_d;
    end

    assign config_out = cfg_q[CFG_W-1];

    // Source 2 is the registered ALU result, so feedback never forms a comb loop.
    for (genvar j = 0; j < NUM_XOUT; j++) begin : g_xbar
        xbar_src_e sel;
        assign sel = xbar_src_e'(cfg_q[SEL_LSB + SEL_W*j +: SEL_W]);
        always_comb begin
            xbar[j] = in0;
            case (sel)
                SRC_IN0: xbar[j] = in0;
                SRC_IN1: xbar[j] = in1;
                SRC_ALU: xbar[j] = alu_res;
                SRC_MEM: xbar[j] = mem_in;
                default: xbar[j] = in0;
            endcase
        end
    end

    alu2 #(.size(size)) u_alu (
        .clk      (clk),
        .reset    (reset),
        .op_i     (alu_op_e'(cfg_q[OP_LSB +: OP_W])),
        .a_i      (xbar[0]),
        .b_i      (xbar[1]),
        .result_o (alu_res)
    );

    assign out0      = cfg_q[OSEL_BIT] ? mem_in : alu_res;
    assign xbar_out2 = xbar[2];
    assign xbar_out3 = xbar[3];

endmodule

// File: tb/tb_pe_alu_xbar.sv
// Self-checking bench for pe_alu_xbar: directed corner cases, an opcode table,
// and random ops checked against an arithmetic reference model.
module tb_pe_alu_xbar;

    logic        clk = 1'b0;
    logic        reset;
    logic        config_en, config_in, config_out;
    logic [31:0] in0, in1, mem_in, out0, xbar_out2, xbar_out3;

    int tests = 0;
    int fails = 0;

    pe_alu_xbar #(.size(32)) dut (
        .clk(clk), .reset(reset), .config_en(config_en), .config_in(config_in),
        .config_out(config_out), .in0(in0), .in1(in1), .mem_in(mem_in),
        .out0(out0), .xbar_out2(xbar_out2), .xbar_out3(xbar_out3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] mk_cfg(input logic [3:0] op, input logic osel,
                                           input logic [1:0] s0, input logic [1:0] s1,
                                           input logic [1:0] s2, input logic [1:0] s3);
        return {s3, s2, s1, s0, osel, op};
    endfunction

    // Reference ALU written from the operation list, not from the RTL.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        int     sh;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        wide = 64'(a) * 64'(b);
        case (op)
            4'd0:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd1:  return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd2:  return wide[31:0];
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
            4'd7:  return 32'(64'(a) / (64'd1 << sh));
            4'd8:  return (sa >= 0) ? 32'(sa / (64'sd1 << sh))
                                    : 32'(-((-sa + (64'sd1 << sh) - 1) / (64'sd1 << sh)));
            4'd9:  return (a == b) ? 32'd1 : 32'd0;
            4'd10: return (sa < sb) ? 32'd1 : 32'd0;
            4'd11: return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'd12: return a;
            4'd13: return b;
            4'd14: return (sa < sb) ? a : b;
            default: return 32'd0;
        endcase
    endfunction

    // Entered and left at a falling edge; 13 rising edges shift the word in MSB first.
    task automatic load_cfg(input logic [12:0] v);
        for (int i = 12; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = v[i];
            @(negedge clk);
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    vec_t vt[$];

    initial begin
        logic [12:0] v;
        logic [1:0]  s0, s1;
        logic [3:0]  op;
        logic [31:0] a, b;

        vt.push_back('{4'd0,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4});
        vt.push_back('{4'd1,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFEC});
        vt.push_back('{4'd2,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFC0});
        vt.push_back('{4'd3,  32'hFFFF_FFF0, 32'd4, 32'h0000_0000});
        vt.push_back('{4'd4,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4});
        vt.push_back('{4'd5,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF4});
        vt.push_back('{4'd6,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FF00});
        vt.push_back('{4'd7,  32'hFFFF_FFF0, 32'd4, 32'h0FFF_FFFF});
        vt.push_back('{4'd8,  32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFFF});
        vt.push_back('{4'd9,  32'hFFFF_FFF0, 32'd4, 32'h0000_0000});
        vt.push_back('{4'd10, 32'hFFFF_FFF0, 32'd4, 32'h0000_0001});
        vt.push_back('{4'd11, 32'hFFFF_FFF0, 32'd4, 32'h0000_0000});
        vt.push_back('{4'd12, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF0});
        vt.push_back('{4'd13, 32'hFFFF_FFF0, 32'd4, 32'h0000_0004});
        vt.push_back('{4'd14, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF0});
        vt.push_back('{4'd15, 32'hFFFF_FFF0, 32'd4, 32'h0000_0000});
        vt.push_back('{4'd9,  32'h1234_5678, 32'h1234_5678, 32'h0000_0001});
        vt.push_back('{4'd8,  32'h8000_0000, 32'd31, 32'hFFFF_FFFF});

        reset = 1'b1; config_en = 1'b0; config_in = 1'b0;
        in0 = 32'd5; in1 = '0; mem_in = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset cfg: ADD with both operands from in0.
        @(negedge clk);
        chk("default_add", out0, 32'd10);
        load_cfg(mk_cfg(4'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2));
        chk("cfg_out_hi", {31'd0, config_out}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_out0", out0, 32'd0);
        chk("rst_xbar2", xbar_out2, 32'd5);
        chk("rst_cfgout", {31'd0, config_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // SUB load, then shift the pattern back out of config_out.
        v = mk_cfg(4'd1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0);
        load_cfg(v);
        in0 = 32'd10; in1 = 32'd3;
        @(negedge clk);
        chk("sub", out0, 32'd7);
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("cfg_shift%0d", i), {31'd0, config_out}, {31'd0, v[12-i]});
            config_en = 1'b1; config_in = 1'b0;
            @(negedge clk);
        end
        config_en = 1'b0;

        // Opcode table with a=in0, b=in1.
        foreach (vt[k]) begin
            in0 = vt[k].a; in1 = vt[k].b;
            load_cfg(mk_cfg(vt[k].op, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0));
            @(negedge clk);
            chk($sformatf("op%0d", vt[k].op), out0, vt[k].exp);
        end

        // Accumulator: with all-zero inputs every partial config computes 0.
        in0 = '0; in1 = '0; mem_in = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        load_cfg(mk_cfg(4'd0, 1'b0, 2'd2, 2'd1, 2'd0, 2'd0));
        chk("acc_start", out0, 32'd0);
        in1 = 32'd1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("acc%0d", i), out0, 32'(i));
        end

        // Memory path is combinational to out0 and the memory-side crossbar outputs.
        load_cfg(mk_cfg(4'd0, 1'b1, 2'd0, 2'd1, 2'd1, 2'd3));
        in1 = 32'h1234; mem_in = 32'hABCD;
        #1;
        chk("mem_out0", out0, 32'hABCD);
        chk("mem_xbar3", xbar_out3, 32'hABCD);
        chk("mem_xbar2", xbar_out2, 32'h1234);
        @(negedge clk);

        // Broadcast in1 to every crossbar output.
        load_cfg(mk_cfg(4'd12, 1'b0, 2'd1, 2'd1, 2'd1, 2'd1));
        in0 = '0; in1 = 32'h55;
        #1;
        chk("bc_xbar2", xbar_out2, 32'h55);
        chk("bc_xbar3", xbar_out3, 32'h55);
        @(negedge clk);
        chk("bc_out0", out0, 32'h55);

        // Random ops with operands drawn from in0, in1 or mem_in.
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            s0 = 2'($urandom_range(0, 2)); if (s0 == 2'd2) s0 = 2'd3;
            s1 = 2'($urandom_range(0, 2)); if (s1 == 2'd2) s1 = 2'd3;
            in0 = $urandom; in1 = $urandom; mem_in = $urandom;
            if (n % 4 == 0) in1 = 32'($urandom_range(0, 40));
            if (n % 5 == 0) mem_in = in0;
            a = (s0 == 2'd0) ? in0 : (s0 == 2'd1) ? in1 : mem_in;
            b = (s1 == 2'd0) ? in0 : (s1 == 2'd1) ? in1 : mem_in;
            load_cfg(mk_cfg(op, 1'b0, s0, s1, 2'd0, 2'd1));
            @(negedge clk);
            chk($sformatf("rnd%0d_op%0d", n, op), out0, ref_alu(op, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
